// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared types, widths and the address legality check for dmem_arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int MEM_BYTES_DEF = 100;
  function automatic logic addr_err(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] lim, input logic align);
    return (a > lim) || (align && a[2:0] != 3'd0);
  endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester + memory bus; master = requesters/memory side, slave = arbiter
interface dmem_arbiter_if #(parameter int N_REQ = 2);
  import dmem_arb_pkg::*;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] req_we;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic rsp_err;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Write_Data;
  logic Mem_Read;
  logic Mem_Write;
  logic [DATA_W-1:0] Read_Data;
  modport master (
    output req, req_we, req_addr, req_wdata, Read_Data,
    input gnt, rsp_valid, rsp_rdata, rsp_err, Mem_Addr, Write_Data, Mem_Read, Mem_Write
  );
  modport slave (
    input req, req_we, req_addr, req_wdata, Read_Data,
    output gnt, rsp_valid, rsp_rdata, rsp_err, Mem_Addr, Write_Data, Mem_Read, Mem_Write
  );
endinterface

// File: rtl/dmem_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick (i_req, i_ptr start index -> o_gnt one-hot, o_idx, o_any)
module rr_arbiter #(
  parameter int N_REQ = 2,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);
  int j;
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    j = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(i_ptr) + k) % N_REQ;
      if (i_req[j]) begin
        o_gnt = '0;
        o_gnt[j] = 1'b1;
        o_idx = IW'(j);
        o_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin data-memory arbiter (ports clk, reset, bus slave; grant_cnt/err_cnt when DMEM_ARB_STATS_EN)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int ALIGN_CHK = 1
) (
  input logic clk,
  input logic reset,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [N_REQ*32-1:0] grant_cnt,
  output logic [31:0] err_cnt
`endif
);
  localparam int IW = $clog2(N_REQ);
  localparam logic [ADDR_W-1:0] LIM = ADDR_W'(MEM_BYTES - 8);
  state_t r_state, w_next;
  logic [IW-1:0] r_ptr, r_widx, w_idx;
  logic [N_REQ-1:0] w_gnt;
  logic w_any, w_take, w_acc, r_we, r_err;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .i_req(bus.req),
    .i_ptr(r_ptr),
    .o_gnt(w_gnt),
    .o_idx(w_idx),
    .o_any(w_any)
  );
  assign w_take = r_state == IDLE && w_any && !reset;
  assign w_acc = r_state == ACCESS && !r_err;
  assign w_addr = bus.req_addr[ADDR_W*w_idx +: ADDR_W];
  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_next;
  always_comb
    w_next = r_state == IDLE ? (w_any ? ACCESS : IDLE) : r_state == ACCESS ? RESP : IDLE;
  always_comb begin
    bus.gnt = w_take ? w_gnt : '0;
    bus.Mem_Read = w_acc && !r_we;
    bus.Mem_Write = w_acc && r_we;
    bus.Mem_Addr = w_acc ? r_addr : '0;
    bus.Write_Data = w_acc ? r_wdata : '0;
    bus.rsp_valid = r_state == RESP ? N_REQ'(1) << r_widx : '0;
    bus.rsp_rdata = r_state == RESP ? r_rdata : '0;
    bus.rsp_err = r_state == RESP && r_err;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
      r_widx <= '0;
      r_we <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_err <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_take) begin
        r_widx <= w_idx;
        r_ptr <= int'(w_idx) == N_REQ - 1 ? '0 : w_idx + IW'(1);
        r_we <= bus.req_we[w_idx];
        r_addr <= w_addr;
        r_wdata <= bus.req_wdata[DATA_W*w_idx +: DATA_W];
        r_err <= addr_err(w_addr, LIM, ALIGN_CHK != 0);
      end
      if (r_state == ACCESS)
        r_rdata <= bus.Mem_Read ? bus.Read_Data : '0;
    end
  end
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] r_gcnt [N_REQ];
  logic [31:0] r_ecnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_REQ; k++) r_gcnt[k] <= '0;
      r_ecnt <= '0;
    end else begin
      if (w_take) r_gcnt[w_idx] <= r_gcnt[w_idx] + 32'd1;
      if (r_state == RESP && r_err && r_ecnt != '1) r_ecnt <= r_ecnt + 32'd1;
    end
  end
  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
    assign grant_cnt[32*g +: 32] = r_gcnt[g];
  end
  assign err_cnt = r_ecnt;
`endif
endmodule
